// File: rtl/axi_line_mngr.sv
// axi_line_mngr: one 128-bit line request as a 4-beat AXI write or read burst; ports: req_*/resp_* client side, aw/w/b/ar/r manager side.
module axi_line_mngr #(
  parameter logic [3:0] MID = 4'h1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  input  logic [15:0]  req_wmask,
  output logic         resp_valid,
  output logic [127:0] resp_rdata,
  output logic         resp_err,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [5:0]   awatop,
  output logic         wvalid,
  input  logic         wready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  input  logic         bvalid,
  output logic         bready,
  input  logic [3:0]   bid,
  input  logic         bcomp,
  output logic         arvalid,
  input  logic         arready,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  input  logic         rvalid,
  output logic         rready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic         rlast
);
  typedef enum logic [2:0] {IDLE, AW, WD, BW, AR, RD, RSP} state_t;
  state_t state, state_nx;
  logic [31:0] addr;
  logic [127:0] line;
  logic [15:0] mask;
  logic [1:0] k;
  logic err;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      k <= 2'd0;
      err <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (req_valid && req_ready) begin
        addr <= req_addr;
        line <= req_wdata;
        mask <= req_wmask;
        err <= 1'b0;
      end
      if ((awvalid && awready) || (arvalid && arready)) k <= 2'd0;
      if (wvalid && wready) k <= k + 2'd1;
      if (bready && bvalid) err <= (bid != MID) | ~bcomp;
      if (rready && rvalid) begin
        resp_rdata[32*k +: 32] <= rdata;
        k <= k + 2'd1;
        err <= err | (rid != MID) | (rlast ? k != 2'd3 : k == 2'd3);
      end
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = req_valid ? (req_we ? AW : AR) : IDLE;
      AW:   state_nx = awready ? WD : AW;
      WD:   state_nx = (wready && k == 2'd3) ? BW : WD;
      BW:   state_nx = bvalid ? RSP : BW;
      AR:   state_nx = arready ? RD : AR;
      RD:   state_nx = (rvalid && rlast) ? RSP : RD;
      default: state_nx = IDLE;
    endcase
  end
  assign req_ready  = state == IDLE;
  assign awvalid    = state == AW;
  assign awid       = MID;
  assign awaddr     = addr & 32'hFFFF_FFF0;
  assign awatop     = 6'h0;
  assign wvalid     = state == WD;
  assign wdata      = line[32*k +: 32];
  assign wstrb      = mask[4*k +: 4];
  assign wlast      = wvalid && k == 2'd3;
  assign bready     = state == BW;
  assign arvalid    = state == AR;
  assign arid       = MID;
  assign araddr     = addr & 32'hFFFF_FFF0;
  assign rready     = state == RD;
  assign resp_valid = state == RSP;
  assign resp_err   = resp_valid & err;
endmodule

// File: tb/tb_axi_line_mngr.sv
// tb_axi_line_mngr: randomized subordinate plus line-level reference model for axi_line_mngr.
module tb_axi_line_mngr;
  localparam logic [3:0] MID = 4'h1;
  logic clk, rst;
  logic req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0] req_wmask;
  logic resp_valid, resp_err;
  logic [127:0] resp_rdata;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, bcomp;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [3:0] awid, bid, arid, rid, wstrb;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [5:0] awatop;
  int checks = 0;
  int errors = 0;
  logic [127:0] model_rdata = '0;
  axi_line_mngr #(.MID(MID)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awatop(awatop),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bcomp(bcomp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rlast(rlast)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle_bus();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_valids"}, {awvalid, wvalid, wlast, bready, arvalid, rready, resp_valid}, 7'h0);
    check({tag, "_req_ready"}, req_ready, 1'b1);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] m,
                          input bit bad_id, input bit comp, input bit rnd, input int aw_hold,
                          input int rst_at);
    bit done;
    int wn, an;
    logic exp_err;
    exp_err = bad_id | ~comp;
    check("wr_req_ready", req_ready, 1'b1);
    req_valid = 1; req_we = 1; req_addr = a; req_wdata = d; req_wmask = m;
    bid = bad_id ? MID + 4'h1 : MID; bcomp = comp;
    @(negedge clk);
    req_valid = 0; req_wdata = $urandom; req_addr = $urandom; req_wmask = $urandom;
    done = 0; wn = 0; an = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (rst_at >= 0 && wn == rst_at) begin
        rst = 1; idle_bus();
        @(negedge clk);
        check_quiet("rst_mid");
        check("rst_mid_rdata", resp_rdata, 128'h0);
        rst = 0; model_rdata = '0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_quiet("rst_after");
        end
        done = 1;
      end else begin
        awready = (cyc < aw_hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (resp_valid) begin
          check("wr_err", resp_err, exp_err);
          check("wr_beats", wn, 4);
          check("wr_aw_count", an, 1);
          check("wr_rdata_kept", resp_rdata, model_rdata);
          done = 1;
        end else begin
          check("wr_no_read", {arvalid, rready}, 2'b00);
          if (awvalid) begin
            check("wr_awaddr", awaddr, {a[31:4], 4'h0});
            check("wr_awid_atop", {awid, awatop}, {MID, 6'h0});
            if (awready) an++;
          end
          if (wvalid) begin
            check("wr_w_after_aw", an, 1);
            check("wr_wdata", wdata, d[32*wn +: 32]);
            check("wr_wstrb", wstrb, m[4*wn +: 4]);
            check("wr_wlast", wlast, wn == 3);
            if (wready) wn++;
          end
          if (bready) check("wr_b_after_w", wn, 4);
        end
        @(negedge clk);
      end
    end
    if (!done) check("wr_timeout", 0, 1);
    idle_bus();
    #1;
    check("wr_resp_once", resp_valid, 1'b0);
    check("wr_next_ready", req_ready, 1'b1);
  endtask
  task automatic do_read(input logic [31:0] a, input logic [255:0] bv, input int n,
                         input int bad, input bit rnd);
    bit done;
    int idx, an;
    logic exp_err;
    logic [127:0] exp_line;
    exp_err = (n != 4) || (bad >= 0 && bad < n);
    exp_line = model_rdata;
    for (int i = 0; i < n; i++) exp_line[32*(i%4) +: 32] = bv[32*i +: 32];
    check("rd_req_ready", req_ready, 1'b1);
    req_valid = 1; req_we = 0; req_addr = a; req_wdata = $urandom;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom;
    done = 0; idx = 0; an = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      rvalid = (idx < n) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      rdata = (idx < n) ? bv[32*(idx%8) +: 32] : 32'h0;
      rlast = idx == n - 1;
      rid = (idx == bad) ? MID + 4'h1 : MID;
      #1;
      if (resp_valid) begin
        check("rd_err", resp_err, exp_err);
        check("rd_rdata", resp_rdata, exp_line);
        check("rd_beats", idx, n);
        check("rd_ar_count", an, 1);
        model_rdata = exp_line;
        done = 1;
      end else begin
        check("rd_no_write", {awvalid, wvalid, bready}, 3'b000);
        if (arvalid) begin
          check("rd_araddr", araddr, {a[31:4], 4'h0});
          check("rd_arid", arid, MID);
          if (arready) an++;
        end
        if (rready) begin
          check("rd_r_after_ar", an, 1);
          if (rvalid) idx++;
        end
      end
      @(negedge clk);
    end
    if (!done) check("rd_timeout", 0, 1);
    idle_bus();
    #1;
    check("rd_resp_once", resp_valid, 1'b0);
    check("rd_next_ready", req_ready, 1'b1);
  endtask
  function automatic logic [255:0] rand_beats();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction
  initial begin
    logic [255:0] bv;
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wmask = 0;
    bid = MID; bcomp = 1; rid = MID; rdata = 0;
    idle_bus();
    repeat (3) @(negedge clk);
    check("reset_valids", {awvalid, wvalid, wlast, bready, arvalid, rready, resp_valid}, 7'h0);
    check("reset_rdata", resp_rdata, 128'h0);
    rst = 0;
    @(negedge clk);
    check_quiet("post_reset");
    do_write(32'h1000_0004, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 16'hFFFF, 0, 1, 0, 0, -1);
    bv = {128'h0, 32'hD3, 32'hC2, 32'hB1, 32'hA0};
    do_read(32'h2000_0010, bv, 4, -1, 0);
    check("rd_directed_line", resp_rdata, 128'h0000_00D3_0000_00C2_0000_00B1_0000_00A0);
    do_write($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'h00F0, 0, 1, 1, 5, -1);
    do_write($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 0, 1, 1, 0, -1);
    do_read($urandom, rand_beats(), 4, 1, 0);
    do_read($urandom, rand_beats(), 2, -1, 0);
    do_read($urandom, rand_beats(), 6, -1, 1);
    do_write($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 0, 0, 0, 0, -1);
    do_write($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1, 1, 1, 0, -1);
    do_write($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'hA5A5, 0, 1, 0, 0, 2);
    do_read($urandom, rand_beats(), 4, -1, 1);
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, 1, 0,
                 ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1);
      else
        do_read($urandom, rand_beats(),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 4,
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
